// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package spi_arb_pkg;

    typedef enum logic {
        DUMMY,
        ACTIVE
    } arb_state_t;

    localparam logic [7:0]  IDLE_ADDR_DEFAULT = 8'hFF;
    localparam int unsigned MEM_DEPTH         = 32;

endpackage

// File: rtl/spi_arbiter_if.sv
// Command/response bus between the arbiter (master) and the SPI memory interface (slave).
interface spi_arbiter_if;

    logic       spi_wr;
    logic [7:0] spi_addr;
    logic [7:0] spi_din;
    logic       spi_done;
    logic       spi_err;
    logic [7:0] spi_dout;

    modport master (
        output spi_wr, spi_addr, spi_din,
        input  spi_done, spi_err, spi_dout
    );

    modport slave (
        input  spi_wr, spi_addr, spi_din,
        output spi_done, spi_err, spi_dout
    );

endinterface

// File: rtl/spi_rr_picker.sv
// Rotate-and-priority-encode: first set req bit at or after ptr (wrapping) wins.
module spi_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        win   = '0;
        valid = 1'b0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (32'(ptr) + off) % NREQ;
            if (!valid && req[PW'(idx)]) begin
                win[PW'(idx)] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Arbiter sharing one SPI memory interface among NREQ requesters; a dummy read is presented when idle.
// SPI_ARB_RR_EN selects round-robin; undefined gives fixed priority (lowest index wins).
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter logic [7:0]  IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_dout,
    output logic              rsp_err,
    output logic              busy,
    spi_arbiter_if.master     spi
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] pick_win;
    logic            pick_valid;
    logic            sel_wr;
    logic [7:0]      sel_addr, sel_din;
    logic            cmd_wr, cmd_wr_d;
    logic [7:0]      cmd_addr, cmd_addr_d, cmd_din, cmd_din_d;
    logic [NREQ-1:0] gnt_d, rsp_valid_d;
    logic [7:0]      rsp_dout_d;
    logic            rsp_err_d, busy_d;

`ifdef SPI_ARB_RR_EN
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (pick_win[i]) win_idx = PW'(i);
    end

    // Pointer moves past the winner so the new owner ranks last next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (spi.spi_done && pick_valid)
            ptr <= (32'(win_idx) == NREQ - 1) ? '0 : PW'(win_idx + 1'b1);
    end
`else
    localparam logic [PW-1:0] ptr = '0;
`endif

    spi_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_win[i]) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[8*i +: 8];
                sel_din  = req_din[8*i +: 8];
            end
        end
    end

    // Command registers only move on spi_done; the interface re-reads them mid-transaction.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt;
        rsp_valid_d = '0;
        rsp_dout_d  = rsp_dout;
        rsp_err_d   = rsp_err;
        busy_d      = busy;
        cmd_wr_d    = cmd_wr;
        cmd_addr_d  = cmd_addr;
        cmd_din_d   = cmd_din;
        if (spi.spi_done) begin
            if (state_q == ACTIVE) begin
                rsp_valid_d = gnt;
                rsp_dout_d  = spi.spi_dout;
                rsp_err_d   = spi.spi_err;
            end
            if (pick_valid) begin
                state_d    = ACTIVE;
                gnt_d      = pick_win;
                busy_d     = 1'b1;
                cmd_wr_d   = sel_wr;
                cmd_addr_d = sel_addr;
                cmd_din_d  = sel_din;
            end else begin
                state_d    = DUMMY;
                gnt_d      = '0;
                busy_d     = 1'b0;
                cmd_wr_d   = 1'b0;
                cmd_addr_d = IDLE_ADDR;
                cmd_din_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DUMMY;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_dout  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= IDLE_ADDR;
            cmd_din   <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_dout  <= rsp_dout_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            cmd_wr    <= cmd_wr_d;
            cmd_addr  <= cmd_addr_d;
            cmd_din   <= cmd_din_d;
        end
    end

    assign spi.spi_wr   = cmd_wr;
    assign spi.spi_addr = cmd_addr;
    assign spi.spi_din  = cmd_din;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small SPI memory model driving spi_done.
// Expectations follow SPI_ARB_RR_EN (round-robin) or fixed priority when undefined.
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int unsigned NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [8*NREQ-1:0] req_addr = '0;
    logic [8*NREQ-1:0] req_din = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_dout;
    logic              rsp_err;
    logic              busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] mem [MEM_DEPTH];

    spi_arbiter_if sbus ();

    spi_arbiter #(.NREQ(NREQ), .IDLE_ADDR(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .spi       (sbus)
    );

    always #5 clk = ~clk;

    // Memory model: idle/load gap, then a done pulse answering the presented command.
    task automatic done_pulse();
        logic [7:0] a;
        repeat (3) @(negedge clk);
        a = sbus.spi_addr;
        if (a >= MEM_DEPTH) begin
            sbus.spi_err  = 1'b1;
            sbus.spi_dout = 8'h00;
        end else begin
            sbus.spi_err  = 1'b0;
            sbus.spi_dout = sbus.spi_wr ? 8'h00 : mem[a[4:0]];
            if (sbus.spi_wr) mem[a[4:0]] = sbus.spi_din;
        end
        sbus.spi_done = 1'b1;
        @(posedge clk);
        #1;
        sbus.spi_done = 1'b0;
        sbus.spi_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, rsp_dout, rsp_err, busy} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b dout=%h err=%b busy=%b, expected all zero",
                     gnt, rsp_valid, rsp_dout, rsp_err, busy);
        end
        checks++;
        if ({sbus.spi_wr, sbus.spi_addr, sbus.spi_din} !== {1'b0, 8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL reset_cmd: got wr=%b addr=%h din=%h, expected wr=0 addr=ff din=00",
                     sbus.spi_wr, sbus.spi_addr, sbus.spi_din);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int n = 0; n < 10; n++) begin
            done_pulse();
            checks++;
            if ({sbus.spi_addr, sbus.spi_wr, gnt, rsp_valid, busy} !== {8'hFF, 1'b0, 4'h0, 4'h0, 1'b0}) begin
                errors++;
                $display("FAIL idle_%0d: got addr=%h wr=%b gnt=%b rv=%b busy=%b, expected addr=ff wr=0 gnt=0 rv=0 busy=0",
                         n, sbus.spi_addr, sbus.spi_wr, gnt, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req[1] = 1'b1; req_wr[1] = 1'b1; req_addr[15:8] = 8'd5; req_din[15:8] = 8'hA5;
        done_pulse();
        checks++;
        if ({gnt, busy, sbus.spi_wr, sbus.spi_addr, sbus.spi_din, rsp_valid} !== {4'b0010, 1'b1, 1'b1, 8'd5, 8'hA5, 4'b0000}) begin
            errors++;
            $display("FAIL wr_grant: got gnt=%b busy=%b wr=%b addr=%h din=%h rv=%b, expected 0010 1 1 05 a5 0000",
                     gnt, busy, sbus.spi_wr, sbus.spi_addr, sbus.spi_din, rsp_valid);
        end
        @(negedge clk);
        req_wr[1] = 1'b0;
        done_pulse();
        checks++;
        if ({rsp_valid, rsp_err, gnt, sbus.spi_wr, sbus.spi_addr} !== {4'b0010, 1'b0, 4'b0010, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL wr_done_rd_grant: got rv=%b err=%b gnt=%b wr=%b addr=%h, expected 0010 0 0010 0 05",
                     rsp_valid, rsp_err, gnt, sbus.spi_wr, sbus.spi_addr);
        end
        @(negedge clk);
        req[1] = 1'b0;
        done_pulse();
        checks++;
        if ({rsp_valid, rsp_dout, rsp_err, gnt, busy, sbus.spi_addr} !== {4'b0010, 8'hA5, 1'b0, 4'b0000, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL rd_done: got rv=%b dout=%h err=%b gnt=%b busy=%b addr=%h, expected 0010 a5 0 0000 0 ff",
                     rsp_valid, rsp_dout, rsp_err, gnt, busy, sbus.spi_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [3];
        logic [NREQ-1:0] exp_v [4];
        logic [7:0]      exp_a [3];
`ifdef SPI_ARB_RR_EN
        exp_g = '{4'b0001, 4'b0100, 4'b1000};
        exp_a = '{8'd10, 8'd12, 8'd13};
        exp_v = '{4'b0000, 4'b0001, 4'b0100, 4'b1000};
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001};
        exp_a = '{8'd10, 8'd10, 8'd10};
        exp_v = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
`endif
        do_reset();
        req_wr   = '0;
        req_addr = {8'd13, 8'd12, 8'd11, 8'd10};
        req      = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            done_pulse();
            checks++;
            if ({gnt, rsp_valid, sbus.spi_addr} !== {exp_g[n], exp_v[n], exp_a[n]}) begin
                errors++;
                $display("FAIL rr_step_%0d: got gnt=%b rv=%b addr=%h, expected gnt=%b rv=%b addr=%h",
                         n, gnt, rsp_valid, sbus.spi_addr, exp_g[n], exp_v[n], exp_a[n]);
            end
        end
        @(negedge clk);
        req = '0;
        done_pulse();
        checks++;
        if ({gnt, rsp_valid, busy} !== {4'b0000, exp_v[3], 1'b0}) begin
            errors++;
            $display("FAIL rr_drain: got gnt=%b rv=%b busy=%b, expected gnt=0000 rv=%b busy=0",
                     gnt, rsp_valid, busy, exp_v[3]);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        req_wr = '0;
        req[2] = 1'b1; req_addr[23:16] = 8'd40;
        done_pulse();
        checks++;
        if ({gnt, sbus.spi_addr} !== {4'b0100, 8'd40}) begin
            errors++;
            $display("FAIL err_grant: got gnt=%b addr=%h, expected gnt=0100 addr=28", gnt, sbus.spi_addr);
        end
        @(negedge clk);
        req[2] = 1'b0;
        req[3] = 1'b1; req_addr[31:24] = 8'd7;
        done_pulse();
        checks++;
        if ({rsp_valid, rsp_err, gnt, sbus.spi_addr} !== {4'b0100, 1'b1, 4'b1000, 8'd7}) begin
            errors++;
            $display("FAIL err_rsp: got rv=%b err=%b gnt=%b addr=%h, expected rv=0100 err=1 gnt=1000 addr=07",
                     rsp_valid, rsp_err, gnt, sbus.spi_addr);
        end
        @(negedge clk);
        req[3] = 1'b0;
        done_pulse();
        checks++;
        if ({rsp_valid, rsp_err, rsp_dout} !== {4'b1000, 1'b0, 8'h37}) begin
            errors++;
            $display("FAIL err_next: got rv=%b err=%b dout=%h, expected rv=1000 err=0 dout=37",
                     rsp_valid, rsp_err, rsp_dout);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        req[0] = 1'b1; req_wr[0] = 1'b1; req_addr[7:0] = 8'd9; req_din[7:0] = 8'h5A;
        done_pulse();
        @(negedge clk);
        req[0] = 1'b0; req_addr[7:0] = 8'h11; req_din[7:0] = 8'h00; req_wr[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({gnt, sbus.spi_wr, sbus.spi_addr, sbus.spi_din} !== {4'b0001, 1'b1, 8'd9, 8'h5A}) begin
            errors++;
            $display("FAIL hold_cmd: got gnt=%b wr=%b addr=%h din=%h, expected 0001 1 09 5a",
                     gnt, sbus.spi_wr, sbus.spi_addr, sbus.spi_din);
        end
        done_pulse();
        checks++;
        if ({rsp_valid, gnt, busy, sbus.spi_addr} !== {4'b0001, 4'b0000, 1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL hold_done: got rv=%b gnt=%b busy=%b addr=%h, expected 0001 0000 0 ff",
                     rsp_valid, gnt, busy, sbus.spi_addr);
        end
        checks++;
        if (mem[9] !== 8'h5A) begin
            errors++;
            $display("FAIL hold_write: got mem[9]=%h, expected 5a", mem[9]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req[1] = 1'b1; req_wr[1] = 1'b0; req_addr[15:8] = 8'd3;
        done_pulse();
        checks++;
        if ({gnt, sbus.spi_addr} !== {4'b0010, 8'd3}) begin
            errors++;
            $display("FAIL rstmid_grant: got gnt=%b addr=%h, expected 0010 03", gnt, sbus.spi_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, rsp_valid, sbus.spi_addr} !== {4'b0000, 1'b0, 4'b0000, 8'hFF}) begin
            errors++;
            $display("FAIL rstmid_async: got gnt=%b busy=%b rv=%b addr=%h, expected 0000 0 0000 ff",
                     gnt, busy, rsp_valid, sbus.spi_addr);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            done_pulse();
            checks++;
            if ({rsp_valid, gnt} !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_after_%0d: got rv=%b gnt=%b, expected 0000 0000", n, rsp_valid, gnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sbus.spi_done = 1'b0;
        sbus.spi_err  = 1'b0;
        sbus.spi_dout = 8'h00;
        for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 8'(8'h30 + i);
        test_reset();
        test_idle();
        test_write_read();
        test_round_robin();
        test_error();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
